// File: rtl/btb_assoc_pkg.sv
// Shared types and helpers for the set-associative branch target buffer:
// 2-bit direction counter encoding and its saturating update functions.
package btb_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT = 2'd0;   // strongly not-taken
    localparam ctr_t CTR_WNT = 2'd1;   // weakly not-taken
    localparam ctr_t CTR_WT  = 2'd2;   // weakly taken (fresh allocation)
    localparam ctr_t CTR_ST  = 2'd3;   // strongly taken

    // Move the counter one step towards taken, holding at strongly-taken.
    function automatic ctr_t ctr_inc(input ctr_t c);
        return (c == CTR_ST) ? c : c + 2'd1;
    endfunction

    // Move the counter one step towards not-taken, holding at strongly-not-taken.
    function automatic ctr_t ctr_dec(input ctr_t c);
        return (c == CTR_SNT) ? c : c - 2'd1;
    endfunction

endpackage

// File: rtl/btb_assoc_plru_tree.sv
// Tree pseudo-LRU helper for one set. Node n has children 2n+1 (left,
// lower way numbers) and 2n+2 (right). A node bit of 0 means the victim
// lies in the left subtree, 1 means the right subtree. Touching a way
// points every node on its path away from it. Purely combinational.
module plru_tree #(
    parameter  int NUM_WAYS = 2,
    localparam int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
    localparam int TREE_W   = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1
) (
    input  logic [TREE_W-1:0] i_bits,
    input  logic [WAY_W-1:0]  i_touch,
    output logic [TREE_W-1:0] o_bits,
    output logic [WAY_W-1:0]  o_victim
);

    localparam int LEVELS = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 0;
    // Padded node vector so the walking node index is exactly wide enough.
    localparam int PAD_W  = 2 * NUM_WAYS;
    localparam int NODE_W = $clog2(PAD_W);

    logic [PAD_W-1:0]  w_cur;
    logic [PAD_W-1:0]  w_new;
    logic [NODE_W-1:0] w_node;
    logic [WAY_W-1:0]  w_path;
    logic              w_dir;

    // Walk the touched way's path (MSB first) and the current victim path.
    always_comb begin
        w_cur = '0;
        w_cur[TREE_W-1:0] = i_bits;
        w_new    = w_cur;
        w_node   = '0;
        w_path   = i_touch;
        w_dir    = 1'b0;
        o_victim = '0;
        for (int l = 0; l < LEVELS; l++) begin
            w_dir          = w_path[WAY_W-1];
            w_new[w_node]  = ~w_dir;
            w_node         = NODE_W'(2 * w_node + 1 + w_dir);
            w_path         = w_path << 1;
        end
        w_node = '0;
        for (int l = 0; l < LEVELS; l++) begin
            w_dir    = w_cur[w_node];
            o_victim = WAY_W'(2 * o_victim + w_dir);
            w_node   = NODE_W'(2 * w_node + 1 + w_dir);
        end
        o_bits = w_new[TREE_W-1:0];
    end

endmodule

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer. Combinational lookup for fetch,
// one update per cycle from execute, global flush of valid bits.
module btb_assoc
    import btb_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NUM_SETS = 64,
    parameter int NUM_WAYS = 2,
    parameter int TAG_BITS = 16
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [XLEN-1:0] if_PC,
    input  logic            flush,
    input  logic            ex_valid,
    input  logic            ex_branch,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_PC,
    input  logic [XLEN-1:0] ex_target_PC,
    output logic            btb_hit,
    output logic            btb_taken,
    output logic [XLEN-1:0] btb_target_PC
);

    localparam int IDX_BITS = $clog2(NUM_SETS);
    localparam int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int TREE_W   = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1;
    localparam int TAG_LO   = IDX_BITS + 2;

    // Entry layout; widths follow this instance's parameters.
    typedef struct packed {
        logic                valid;
        logic [TAG_BITS-1:0] tag;
        logic [XLEN-1:0]     target;
        ctr_t                ctr;
    } BTB_ENTRY;

    BTB_ENTRY            r_entry [NUM_SETS][NUM_WAYS];
    logic [TREE_W-1:0]   r_plru  [NUM_SETS];

    logic [IDX_BITS-1:0] w_if_idx;
    logic [TAG_BITS-1:0] w_if_tag;
    logic [IDX_BITS-1:0] w_ex_idx;
    logic [TAG_BITS-1:0] w_ex_tag;
    logic [NUM_WAYS-1:0] w_rd_match;
    logic [NUM_WAYS-1:0] w_up_match;
    logic                w_hit;
    BTB_ENTRY            w_hit_entry;
    logic                w_up_hit;
    logic [WAY_W-1:0]    w_up_way;
    logic [WAY_W-1:0]    w_alloc_way;
    logic [WAY_W-1:0]    w_touch_way;
    logic [WAY_W-1:0]    w_plru_victim;
    logic [TREE_W-1:0]   w_plru_next;
    logic                w_update;
    logic                w_unused;

    assign w_if_idx = if_PC[IDX_BITS+1:2];
    assign w_if_tag = if_PC[TAG_LO+TAG_BITS-1:TAG_LO];
    assign w_ex_idx = ex_PC[IDX_BITS+1:2];
    assign w_ex_tag = ex_PC[TAG_LO+TAG_BITS-1:TAG_LO];
    assign w_update = ex_valid && ex_branch;
    // Offset bits and bits above the tag never take part in matching.
    assign w_unused = ^ex_PC;

    // Per-way tag comparators for the fetch and execute ports.
    for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
        assign w_rd_match[gi] = r_entry[w_if_idx][gi].valid &&
                                (r_entry[w_if_idx][gi].tag == w_if_tag);
        assign w_up_match[gi] = r_entry[w_ex_idx][gi].valid &&
                                (r_entry[w_ex_idx][gi].tag == w_ex_tag);
    end

    // Lookup: tags are unique within a set, so at most one way matches.
    always_comb begin
        w_hit       = 1'b0;
        w_hit_entry = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (w_rd_match[w]) begin
                w_hit       = 1'b1;
                w_hit_entry = r_entry[w_if_idx][w];
            end
        end
    end

    assign btb_hit       = w_hit;
    assign btb_taken     = w_hit && w_hit_entry.ctr[1];
    assign btb_target_PC = btb_taken ? w_hit_entry.target : if_PC + XLEN'(4);

    // Update-side way selection: hit way, else lowest invalid, else PLRU victim.
    always_comb begin
        w_up_hit    = 1'b0;
        w_up_way    = '0;
        w_alloc_way = w_plru_victim;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (w_up_match[w]) begin
                w_up_hit = 1'b1;
                w_up_way = WAY_W'(w);
            end
        end
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!r_entry[w_ex_idx][w].valid) begin
                w_alloc_way = WAY_W'(w);
            end
        end
        w_touch_way = w_up_hit ? w_up_way : w_alloc_way;
    end

    plru_tree #(
        .NUM_WAYS (NUM_WAYS)
    ) u_plru (
        .i_bits   (r_plru[w_ex_idx]),
        .i_touch  (w_touch_way),
        .o_bits   (w_plru_next),
        .o_victim (w_plru_victim)
    );

    // Entry/PLRU state: async clear, then flush beats any same-cycle update.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                r_plru[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    r_entry[s][w] <= '0;
                end
            end
        end else if (flush) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    r_entry[s][w].valid <= 1'b0;
                end
            end
        end else if (w_update) begin
            if (w_up_hit) begin
                r_entry[w_ex_idx][w_up_way].ctr <= ex_taken
                    ? ctr_inc(r_entry[w_ex_idx][w_up_way].ctr)
                    : ctr_dec(r_entry[w_ex_idx][w_up_way].ctr);
                if (ex_taken) begin
                    r_entry[w_ex_idx][w_up_way].target <= ex_target_PC;
                end
                r_plru[w_ex_idx] <= w_plru_next;
            end else if (ex_taken) begin
                r_entry[w_ex_idx][w_alloc_way].valid  <= 1'b1;
                r_entry[w_ex_idx][w_alloc_way].tag    <= w_ex_tag;
                r_entry[w_ex_idx][w_alloc_way].target <= ex_target_PC;
                r_entry[w_ex_idx][w_alloc_way].ctr    <= CTR_WT;
                r_plru[w_ex_idx] <= w_plru_next;
            end
        end
    end

endmodule

// File: tb/tb_btb_assoc.sv
// Directed bench for btb_assoc with default parameters (64 sets, 2 ways).
// Lookups are compared as {hit, taken, target} against hand-derived values.
module tb_btb_assoc;

    logic        clock;
    logic        reset_n;
    logic [31:0] if_PC;
    logic        flush;
    logic        ex_valid;
    logic        ex_branch;
    logic        ex_taken;
    logic [31:0] ex_PC;
    logic [31:0] ex_target_PC;
    logic        btb_hit;
    logic        btb_taken;
    logic [31:0] btb_target_PC;

    int n_tests;
    int n_fail;
    logic [33:0] obs;
    logic [33:0] exp_v;

    btb_assoc dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .if_PC         (if_PC),
        .flush         (flush),
        .ex_valid      (ex_valid),
        .ex_branch     (ex_branch),
        .ex_taken      (ex_taken),
        .ex_PC         (ex_PC),
        .ex_target_PC  (ex_target_PC),
        .btb_hit       (btb_hit),
        .btb_taken     (btb_taken),
        .btb_target_PC (btb_target_PC)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one execute update; entered and left 1 time unit after a rising edge.
    task automatic do_update(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
        ex_valid     = 1'b1;
        ex_branch    = 1'b1;
        ex_taken     = tk;
        ex_PC        = pc;
        ex_target_PC = tgt;
        @(posedge clock);
        #1;
        ex_valid = 1'b0;
        ex_taken = 1'b0;
    endtask

    // Apply a fetch PC and let the combinational lookup settle.
    task automatic look(input logic [31:0] pc);
        if_PC = pc;
        #1;
        obs = {btb_hit, btb_taken, btb_target_PC};
    endtask

    // Clean slate between scenarios.
    task automatic hard_reset();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        do_update(32'h100, 32'h200, 1'b1);
        #2;
        reset_n = 1'b0;
        look(32'h100);
        exp_v = {1'b0, 1'b0, 32'h104};
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL reset_lookup obs=%h exp=%h", obs, exp_v); end
        else $display("[TB] reset_lookup ok %h", obs);
        look(32'hFFFF_FFFC);
        exp_v = {1'b0, 1'b0, 32'h0};
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL reset_wrap obs=%h exp=%h", obs, exp_v); end
        else $display("[TB] reset_wrap ok %h", obs);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        look(32'h100);
        exp_v = {1'b0, 1'b0, 32'h104};
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL reset_after obs=%h exp=%h", obs, exp_v); end
        else $display("[TB] reset_after ok %h", obs);
    endtask

    task automatic test_allocate();
        // Same-cycle lookup sees pre-update state.
        ex_valid = 1'b1; ex_branch = 1'b1; ex_taken = 1'b1;
        ex_PC = 32'h100; ex_target_PC = 32'h200;
        look(32'h100);
        exp_v = {1'b0, 1'b0, 32'h104};
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL alloc_same_cycle obs=%h exp=%h", obs, exp_v); end
        else $display("[TB] alloc_same_cycle ok %h", obs);
        @(posedge clock);
        #1;
        ex_valid = 1'b0;
        look(32'h100);
        exp_v = {1'b1, 1'b1, 32'h200};
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL alloc_next obs=%h exp=%h", obs, exp_v); end
        else $display("[TB] alloc_next ok %h", obs);
    endtask

    task automatic test_counter();
        // ctr 2 -> 1: hit, predicted not-taken.
        do_update(32'h100, 32'h777, 1'b0);
        look(32'h100);
        exp_v = {1'b1, 1'b0, 32'h104};
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL ctr_wnt obs=%h exp=%h", obs, exp_v); end
        else $display("[TB] ctr_wnt ok %h", obs);
        // 1 -> 0 -> 0 (saturate low), then one taken -> 1: still not-taken.
        do_update(32'h100, 32'h777, 1'b0);
        do_update(32'h100, 32'h777, 1'b0);
        do_update(32'h100, 32'h180, 1'b1);
        look(32'h100);
        exp_v = {1'b1, 1'b0, 32'h104};
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL ctr_sat_low obs=%h exp=%h", obs, exp_v); end
        else $display("[TB] ctr_sat_low ok %h", obs);
        // 1 -> 2 -> 3 -> 3, target refreshed by each taken update.
        do_update(32'h100, 32'h240, 1'b1);
        do_update(32'h100, 32'h240, 1'b1);
        do_update(32'h100, 32'h240, 1'b1);
        look(32'h100);
        exp_v = {1'b1, 1'b1, 32'h240};
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL ctr_st obs=%h exp=%h", obs, exp_v); end
        else $display("[TB] ctr_st ok %h", obs);
        // 3 -> 2: still taken; not-taken update must not overwrite target.
        do_update(32'h100, 32'h999, 1'b0);
        look(32'h100);
        exp_v = {1'b1, 1'b1, 32'h240};
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL ctr_hyst obs=%h exp=%h", obs, exp_v); end
        else $display("[TB] ctr_hyst ok %h", obs);
    endtask

    task automatic test_replacement();
        hard_reset();
        do_update(32'h100, 32'h1000, 1'b1);   // way 0
        do_update(32'h200, 32'h2000, 1'b1);   // way 1
        do_update(32'h100, 32'h1100, 1'b1);   // re-touch way 0
        do_update(32'h300, 32'h3000, 1'b1);   // evicts 0x200
        look(32'h100);
        exp_v = {1'b1, 1'b1, 32'h1100};
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL repl_first obs=%h exp=%h", obs, exp_v); end
        else $display("[TB] repl_first ok %h", obs);
        look(32'h200);
        exp_v = {1'b0, 1'b0, 32'h204};
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL repl_evicted obs=%h exp=%h", obs, exp_v); end
        else $display("[TB] repl_evicted ok %h", obs);
        look(32'h300);
        exp_v = {1'b1, 1'b1, 32'h3000};
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL repl_third obs=%h exp=%h", obs, exp_v); end
        else $display("[TB] repl_third ok %h", obs);
    endtask

    task automatic test_flush();
        flush = 1'b1;
        ex_valid = 1'b1; ex_branch = 1'b1; ex_taken = 1'b1;
        ex_PC = 32'h300; ex_target_PC = 32'h3300;
        look(32'h100);
        exp_v = {1'b1, 1'b1, 32'h1100};
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL flush_same_cycle obs=%h exp=%h", obs, exp_v); end
        else $display("[TB] flush_same_cycle ok %h", obs);
        @(posedge clock);
        #1;
        flush = 1'b0;
        ex_valid = 1'b0;
        look(32'h300);
        exp_v = {1'b0, 1'b0, 32'h304};
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL flush_300 obs=%h exp=%h", obs, exp_v); end
        else $display("[TB] flush_300 ok %h", obs);
        look(32'h100);
        exp_v = {1'b0, 1'b0, 32'h104};
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL flush_100 obs=%h exp=%h", obs, exp_v); end
        else $display("[TB] flush_100 ok %h", obs);
    endtask

    task automatic test_miss_not_taken();
        do_update(32'h600, 32'h6000, 1'b0);
        look(32'h600);
        exp_v = {1'b0, 1'b0, 32'h604};
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL miss_nt obs=%h exp=%h", obs, exp_v); end
        else $display("[TB] miss_nt ok %h", obs);
        // A branch that is valid but not marked as a branch must be ignored.
        ex_valid = 1'b1; ex_branch = 1'b0; ex_taken = 1'b1;
        ex_PC = 32'h700; ex_target_PC = 32'h7000;
        @(posedge clock);
        #1;
        ex_valid = 1'b0;
        look(32'h700);
        exp_v = {1'b0, 1'b0, 32'h704};
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL non_branch obs=%h exp=%h", obs, exp_v); end
        else $display("[TB] non_branch ok %h", obs);
    endtask

    task automatic test_back_to_back();
        do_update(32'h104, 32'hA000, 1'b1);   // set 1
        do_update(32'h108, 32'hB000, 1'b1);   // set 2
        look(32'h104);
        exp_v = {1'b1, 1'b1, 32'hA000};
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL b2b_first obs=%h exp=%h", obs, exp_v); end
        else $display("[TB] b2b_first ok %h", obs);
        look(32'h108);
        exp_v = {1'b1, 1'b1, 32'hB000};
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL b2b_second obs=%h exp=%h", obs, exp_v); end
        else $display("[TB] b2b_second ok %h", obs);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        if_PC = '0; flush = 1'b0;
        ex_valid = 1'b0; ex_branch = 1'b0; ex_taken = 1'b0;
        ex_PC = '0; ex_target_PC = '0;
        #12;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        test_reset();
        test_allocate();
        test_counter();
        test_replacement();
        test_flush();
        test_miss_not_taken();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
